// File: rtl/lut_neuron_pkg.sv
// ---------------------------------------------------------------------------
// lut_neuron_pkg
// Shared definitions for the runtime-loadable LUT neuron:
//   - state_t     : controller states (unconfigured / loading / running)
//   - DEF_*       : default geometry of the neuron
//   - lut_depth() : number of table entries for a given address width
// ---------------------------------------------------------------------------
package lut_neuron_pkg;

    typedef enum logic [1:0] {
        S_UNCFG = 2'd0,
        S_LOAD  = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    localparam int DEF_FAN_IN   = 4;
    localparam int DEF_IN_BITS  = 2;
    localparam int DEF_OUT_BITS = 2;

    // Depth is computed directly from the address width, so no log2 helper
    // is needed anywhere in the datapath.
    function automatic int lut_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/lut_neuron_ram.sv
// ---------------------------------------------------------------------------
// lut_neuron_ram
// Truth-table storage: DEPTH x DATA_W, one write port and one registered read
// port with read enable. The read register doubles as the second pipeline
// stage of the neuron, so holding rd_en low freezes the output word.
// Ports:
//   clk      : clock
//   wr_en    : write strobe
//   wr_addr  : write address
//   wr_data  : write data
//   rd_en    : read enable (load the read register)
//   rd_addr  : read address
//   rd_data  : registered read data
// ---------------------------------------------------------------------------
module lut_neuron_ram
    import lut_neuron_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 2
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int DEPTH = lut_depth(ADDR_W);

    (* ram_style = "distributed", rom_style = "distributed" *)
    logic [DATA_W-1:0] mem [DEPTH];

    logic [DATA_W-1:0] rd_data_q;

    // Table contents are intentionally not reset; they are only meaningful
    // after a full load.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/lut_neuron_rt.sv
// ---------------------------------------------------------------------------
// lut_neuron_rt
// Runtime-loadable, pipelined LUT neuron. FAN_IN channels of IN_BITS form a
// table address; the stored OUT_BITS word is the output. The table is filled
// over a config stream at auto-incremented addresses, then the datapath runs
// with valid/ready and full back-pressure (2-stage pipe: address register,
// then RAM read register).
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   cfg_start             : request table (re)load
//   cfg_valid/cfg_data    : config word, cfg_ready high only while loading
//   in_valid/in_data      : input vector, in_ready accepts it
//   out_valid/out_data    : table[in_data], out_ready accepts it
//   configured            : table fully loaded, datapath running
// ---------------------------------------------------------------------------
module lut_neuron_rt
    import lut_neuron_pkg::*;
#(
    parameter int FAN_IN   = DEF_FAN_IN,
    parameter int IN_BITS  = DEF_IN_BITS,
    parameter int OUT_BITS = DEF_OUT_BITS
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cfg_start,
    input  logic                      cfg_valid,
    input  logic [OUT_BITS-1:0]       cfg_data,
    output logic                      cfg_ready,
    input  logic                      in_valid,
    input  logic [FAN_IN*IN_BITS-1:0] in_data,
    output logic                      in_ready,
    output logic                      out_valid,
    output logic [OUT_BITS-1:0]       out_data,
    input  logic                      out_ready,
    output logic                      configured
);

    localparam int              ADDR_W    = FAN_IN * IN_BITS;
    localparam int              DEPTH     = lut_depth(ADDR_W);
    localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W+1)'(1);

    // Reset asserts asynchronously but is released on a clock edge so that
    // no flop sees reset removal close to the active edge.
    logic [1:0] rst_sync_q;
    logic       rst_int_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync_q[1];

    state_t            state_q, state_d;
    logic [ADDR_W:0]   wr_cnt_q, wr_cnt_d;
    logic              s1_v_q, s1_v_d;
    logic [ADDR_W-1:0] s1_addr_q, s1_addr_d;
    logic              s2_v_q, s2_v_d;
    logic              cfg_ready_q, cfg_ready_d;
    logic              configured_q, configured_d;

    logic s1_adv, s2_adv, in_fire, wr_fire;

    // Handshake / advance terms. in_ready drops combinationally on cfg_start
    // so no new vector enters while a reload is pending.
    always_comb begin
        s2_adv   = !s2_v_q || out_ready;
        s1_adv   = !s1_v_q || s2_adv;
        in_ready = (state_q == S_RUN) && !cfg_start && s1_adv;
        in_fire  = in_valid && in_ready;
        wr_fire  = cfg_valid && cfg_ready_q;
    end

    always_comb begin
        state_d   = state_q;
        wr_cnt_d  = wr_cnt_q;
        s1_v_d    = s1_v_q;
        s1_addr_d = s1_addr_q;
        s2_v_d    = s2_v_q;

        unique case (state_q)
            S_UNCFG: begin
                if (cfg_start) begin
                    state_d  = S_LOAD;
                    wr_cnt_d = '0;
                end
            end
            S_LOAD: begin
                if (wr_fire) begin
                    wr_cnt_d = wr_cnt_q + CNT_ONE;
                    if (wr_cnt_q == LAST_ADDR) begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                // Reload waits until both pipeline stages are empty.
                if (cfg_start && !s1_v_q && !s2_v_q) begin
                    state_d  = S_LOAD;
                    wr_cnt_d = '0;
                end
            end
            default: begin
                state_d = S_UNCFG;
            end
        endcase

        if (s1_adv) begin
            s1_v_d = in_fire;
            if (in_fire) begin
                s1_addr_d = in_data;
            end
        end

        if (s2_adv) begin
            s2_v_d = s1_v_q;
        end

        cfg_ready_d  = (state_d == S_LOAD);
        configured_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q      <= S_UNCFG;
            wr_cnt_q     <= '0;
            s1_v_q       <= 1'b0;
            s1_addr_q    <= '0;
            s2_v_q       <= 1'b0;
            cfg_ready_q  <= 1'b0;
            configured_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_cnt_q     <= wr_cnt_d;
            s1_v_q       <= s1_v_d;
            s1_addr_q    <= s1_addr_d;
            s2_v_q       <= s2_v_d;
            cfg_ready_q  <= cfg_ready_d;
            configured_q <= configured_d;
        end
    end

    // The RAM read register is stage 2; it only loads when stage 2 advances,
    // which keeps out_data stable under back-pressure.
    lut_neuron_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (OUT_BITS)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_fire),
        .wr_addr (wr_cnt_q[ADDR_W-1:0]),
        .wr_data (cfg_data),
        .rd_en   (s2_adv),
        .rd_addr (s1_addr_q),
        .rd_data (out_data)
    );

    assign out_valid  = s2_v_q;
    assign cfg_ready  = cfg_ready_q;
    assign configured = configured_q;

endmodule

// File: tb/tb_lut_neuron_rt.sv
// ---------------------------------------------------------------------------
// tb_lut_neuron_rt
// Directed bench for lut_neuron_rt (FAN_IN=4, IN_BITS=2, OUT_BITS=2).
// Inputs are driven 1 time unit after the rising edge, outputs are sampled
// 2 time units after it. A queue of expected words tracks vectors in flight.
// ---------------------------------------------------------------------------
module tb_lut_neuron_rt;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_start;
    logic       cfg_valid;
    logic [1:0] cfg_data;
    logic       cfg_ready;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [1:0] out_data;
    logic       out_ready;
    logic       configured;

    always #5 clk = ~clk;

    lut_neuron_rt #(
        .FAN_IN   (4),
        .IN_BITS  (2),
        .OUT_BITS (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_start  (cfg_start),
        .cfg_valid  (cfg_valid),
        .cfg_data   (cfg_data),
        .cfg_ready  (cfg_ready),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .configured (configured)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [1:0] exp_tab [256];
    logic [1:0] sb [$];
    logic       stall_prev;
    logic [1:0] held_data;
    int         cyc, push_cnt, pop_cnt, first_pop, last_pop;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] tab_val(input int mode, input int a);
        logic [7:0] av;
        av = a[7:0];
        if (mode == 0) return av[1:0] ^ av[7:6];
        return ~av[1:0];
    endfunction

    // One clock cycle of datapath traffic with scoreboard and handshake checks.
    task automatic step(input logic iv, input logic [7:0] d, input logic ordy, input logic cs);
        logic exp_ir;
        logic [1:0] e;
        @(posedge clk);
        #1;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        cfg_start = cs;
        #1;
        cyc++;
        if (stall_prev) begin
            check_eq("hold_valid", out_valid, 1'b1);
            check_eq("hold_data", out_data, held_data);
        end
        if (!configured)      exp_ir = 1'b0;
        else if (cs)          exp_ir = 1'b0;
        else                  exp_ir = !(sb.size() == 2 && !ordy);
        check_eq("in_ready", in_ready, exp_ir);
        if (sb.size() == 0) check_eq("no_spurious_out", out_valid, 1'b0);
        if (out_valid && ordy && sb.size() > 0) begin
            e = sb.pop_front();
            $display("[TB] out data=%0d exp=%0d", out_data, e);
            check_eq("out_data", out_data, e);
            if (pop_cnt == 0) first_pop = cyc;
            last_pop = cyc;
            pop_cnt++;
        end
        if (iv && in_ready) begin
            sb.push_back(exp_tab[d]);
            push_cnt++;
        end
        stall_prev = out_valid && !ordy;
        held_data  = out_data;
    endtask

    task automatic drain(input logic cs);
        for (int k = 0; k < 50 && sb.size() > 0; k++) step(1'b0, 8'h00, 1'b1, cs);
        check_eq("drain_empty", sb.size(), 0);
    endtask

    task automatic clear_stats();
        cyc = 0; push_cnt = 0; pop_cnt = 0; first_pop = 0; last_pop = 0;
    endtask

    // Request a load (cfg_start held until cfg_ready), then write n entries.
    task automatic load_table(input int mode, input int n);
        bit seen = 0;
        in_valid = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(posedge clk);
            #2;
            if (cfg_ready) seen = 1;
            else cfg_start = 1'b1;
        end
        check_eq("ld_cfg_ready", cfg_ready, 1'b1);
        cfg_start = 1'b0;
        check_eq("ld_in_ready", in_ready, 1'b0);
        check_eq("ld_configured", configured, 1'b0);
        for (int a = 0; a < n; a++) begin
            cfg_valid = 1'b1;
            cfg_data  = tab_val(mode, a);
            if (a == 255) check_eq("ld_not_cfg_early", configured, 1'b0);
            @(posedge clk);
            #1;
        end
        cfg_valid = 1'b0;
        for (int a = 0; a < n; a++) exp_tab[a] = tab_val(mode, a);
        $display("[TB] load mode=%0d writes=%0d", mode, n);
        if (n == 256) begin
            #1;
            check_eq("ld_configured_done", configured, 1'b1);
            check_eq("ld_cfg_ready_done", cfg_ready, 1'b0);
        end
    endtask

    // Single vector with latency check: out_valid exactly two cycles later.
    task automatic send_one(input logic [7:0] v, input logic [1:0] exp);
        exp_tab[v] = exp;
        step(1'b1, v, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check_eq("lat_cycle1_valid", out_valid, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check_eq("lat_cycle2_valid", out_valid, 1'b1);
        check_eq("lat_cycle2_data", out_data, exp);
        check_eq("single_empty", sb.size(), 0);
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #3;
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hA6;
        cfg_valid = 1'b1;
        cfg_start = 1'b0;
        #1;
        check_eq("rst_cfg_ready", cfg_ready, 1'b0);
        check_eq("rst_configured", configured, 1'b0);
        check_eq("rst_in_ready", in_ready, 1'b0);
        check_eq("rst_out_valid", out_valid, 1'b0);
        sb.delete();
        stall_prev = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        cfg_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_eq("post_rst_configured", configured, 1'b0);
        check_eq("post_rst_out_valid", out_valid, 1'b0);
        $display("[TB] reset applied");
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_data = 2'b00;
        in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
        stall_prev = 1'b0; held_data = 2'b00;
        for (int a = 0; a < 256; a++) exp_tab[a] = 2'b00;
        clear_stats();
        apply_reset();

        // Unconfigured: in_valid must not produce anything.
        repeat (4) step(1'b1, 8'h55, 1'b1, 1'b0);
        check_eq("uncfg_no_push", push_cnt, 0);

        // Scenario 1: XOR table, two single vectors.
        load_table(0, 256);
        send_one(8'hA6, 2'b00);
        send_one(8'hC1, 2'b10);

        // Scenario 2: 256 back-to-back vectors, full throughput.
        clear_stats();
        for (int i = 0; i < 256; i++) step(1'b1, i[7:0], 1'b1, 1'b0);
        drain(1'b0);
        check_eq("bb_pushes", push_cnt, 256);
        check_eq("bb_pops", pop_cnt, 256);
        check_eq("bb_throughput", last_pop - first_pop, 255);

        // Scenario 3: random gaps and back-pressure.
        clear_stats();
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 2) != 0, 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
        drain(1'b0);
        check_eq("rand_in_out_count", pop_cnt, push_cnt);

        // Scenario 6b: cfg_valid while running must not change the table.
        cfg_valid = 1'b1; cfg_data = 2'b11;
        repeat (3) step(1'b0, 8'h00, 1'b1, 1'b0);
        check_eq("run_cfg_ready", cfg_ready, 1'b0);
        cfg_valid = 1'b0;
        send_one(8'hA6, 2'b00);
        send_one(8'h00, 2'b00);

        // Scenario 4: reload requested with two vectors in flight.
        step(1'b1, 8'hA6, 1'b1, 1'b0);
        step(1'b1, 8'hC1, 1'b0, 1'b0);
        step(1'b1, 8'h11, 1'b0, 1'b1);
        step(1'b1, 8'h11, 1'b0, 1'b1);
        check_eq("reload_in_flight", sb.size(), 2);
        check_eq("reload_hold_cfg_ready", cfg_ready, 1'b0);
        drain(1'b1);
        load_table(1, 256);
        send_one(8'hA6, 2'b01);
        send_one(8'h3F, 2'b00);

        // Scenario 5: reset in the middle of a load, then full reload.
        load_table(0, 100);
        apply_reset();
        repeat (3) step(1'b1, 8'hA6, 1'b1, 1'b0);
        check_eq("rst_in_ignored", sb.size(), 0);
        load_table(0, 256);
        send_one(8'hA6, 2'b00);
        send_one(8'hC1, 2'b10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
